// File: rtl/calc_operand_entry_pkg.sv
// ---------------------------------------------------------------------------
// calc_operand_entry_pkg
//   Shared definitions for the calculator operand-entry front end:
//   opcodes, FSM state encodings, key indices, operand limits and the
//   two-digit shift helper used when a digit key is accepted.
// ---------------------------------------------------------------------------
package calc_operand_entry_pkg;

    // Opcodes as presented on iOP / oOP
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Key indices into iKEY_n and the per-key press vector
    localparam int KEY_DIGIT = 0;
    localparam int KEY_NEXT  = 1;
    localparam int KEY_EXEC  = 2;
    localparam int KEY_CLR   = 3;

    localparam logic [6:0] MAX_OPERAND = 7'd99;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

    // Entry FSM states
    typedef enum logic [1:0] {
        S_A    = 2'd0,   // editing operand A
        S_B    = 2'd1,   // editing operand B
        S_SEND = 2'd2,   // operand set offered to the consumer
        S_DONE = 2'd3    // transfer complete, values held for display
    } state_t;

    // Append a decimal digit, keeping only the last two digits.
    // (v % 10) * 10 is at most 90, so the sum never exceeds MAX_OPERAND.
    function automatic logic [6:0] shift_digit(input logic [6:0] v, input logic [3:0] d);
        logic [6:0] ones;
        ones = v % 7'd10;
        return (ones * 7'd10) + {3'b000, d};
    endfunction

endpackage

// File: rtl/calc_operand_entry_key_debounce.sv
// ---------------------------------------------------------------------------
// calc_operand_entry_key_debounce
//   Conditions one raw active-low push key: two-flop synchronizer, a
//   debounce counter that accepts a new level only after DEBOUNCE_CYCLES
//   consecutive samples that differ from the accepted level, and a single
//   cycle press pulse on the accepted released->pressed edge.
//
// Ports
//   i_clk     system clock
//   i_rst     asynchronous active-high reset (accepted level = released)
//   i_key_n   raw key, active-low, asynchronous to i_clk
//   o_press   one-cycle pulse per accepted press
//   o_level_n accepted (debounced) key level, active-low
// ---------------------------------------------------------------------------
module calc_operand_entry_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press,
    output logic o_level_n
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Synchronizer and accepted level both reset to "released" (high).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level_n <= 1'b1;
            r_cnt     <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level_n) begin
                // Any sample agreeing with the accepted level restarts the count.
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES consecutive differing samples: accept.
                r_level_n <= r_sync2;
                r_cnt     <= '0;
                r_press   <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press   = r_press;
    assign o_level_n = r_level_n;

endmodule

// File: rtl/calc_operand_entry.sv
// ---------------------------------------------------------------------------
// calc_operand_entry
//   Sequential front end of the calculator. Four debounced push keys and the
//   switch bank build operands A and B (0..99) and the opcode, then offer the
//   set to the ALU/display path.
//
// Handshake: oVALID rises when the set is offered and stays high, with
//   oA/oB/oOP frozen, until a cycle where oVALID & iREADY are both high
//   (the transfer). oVALID falls the cycle after the transfer. Only clear
//   or reset withdraw oVALID without a transfer. iREADY may already be
//   high before oVALID rises.
//
// Ports
//   iCLK      system clock
//   iRST      asynchronous active-high reset
//   iKEY_n    raw keys, active-low: [0] digit, [1] next/op, [2] execute, [3] clear
//   iDIGIT    digit value, sampled on a digit press (values > 9 ignored)
//   iOP       opcode, sampled on a next/op press
//   iREADY    consumer accepts the operand set
//   oA, oB    operands, 0..99
//   oOP       latched opcode
//   oVALID    operand set offered
//   oSEL_B    operand B is being edited
//   oERR      divide-by-zero execute was rejected
//   oSTATE    current entry FSM state (debug)
// ---------------------------------------------------------------------------
module calc_operand_entry
    import calc_operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [3:0] iKEY_n,
    input  logic [3:0] iDIGIT,
    input  logic [1:0] iOP,
    input  logic       iREADY,
    output logic [6:0] oA,
    output logic [6:0] oB,
    output logic [1:0] oOP,
    output logic       oVALID,
    output logic       oSEL_B,
    output logic       oERR,
    output logic [1:0] oSTATE
);

    // ---------------------------------------------------------------
    // Key conditioning
    // ---------------------------------------------------------------
    logic [3:0] w_press;
    logic [3:0] w_level_n;

    for (genvar g = 0; g < 4; g++) begin : g_key
        calc_operand_entry_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key (
            .i_clk     (iCLK),
            .i_rst     (iRST),
            .i_key_n   (iKEY_n[g]),
            .o_press   (w_press[g]),
            .o_level_n (w_level_n[g])
        );
    end

    // Same-cycle priority: clear > execute > next/op > digit.
    logic w_clr;
    logic w_exec;
    logic w_next;
    logic w_dig;
    logic w_digit_ok;

    assign w_clr      = w_press[KEY_CLR];
    assign w_exec     = w_press[KEY_EXEC]  & ~w_press[KEY_CLR];
    assign w_next     = w_press[KEY_NEXT]  & ~w_press[KEY_EXEC] & ~w_press[KEY_CLR];
    assign w_dig      = w_press[KEY_DIGIT] & ~w_press[KEY_NEXT] & ~w_press[KEY_EXEC]
                        & ~w_press[KEY_CLR];
    assign w_digit_ok = (iDIGIT <= DIGIT_MAX);

    // ---------------------------------------------------------------
    // Operand / opcode / error registers
    // ---------------------------------------------------------------
    state_t     r_state;
    state_t     w_next_state;
    logic [6:0] r_a;
    logic [6:0] r_b;
    logic [1:0] r_op;
    logic       r_err;
    logic       w_div0;
    logic       w_dig_acc;

    assign w_div0    = (r_op == OP_DIV) && (r_b == 7'd0);
    assign w_dig_acc = w_dig & w_digit_ok;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_err <= 1'b0;
        end else if (w_clr) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_err <= 1'b0;
        end else begin
            // The error flag is only ever set while editing B; any accepted
            // digit or next/op afterwards acknowledges it.
            if (w_next || w_dig_acc) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_A: begin
                    if (w_next) begin
                        r_op <= iOP;
                        r_b  <= '0;
                    end else if (w_dig_acc) begin
                        r_a <= shift_digit(r_a, iDIGIT);
                    end
                end
                S_B: begin
                    if (w_exec && w_div0) begin
                        r_err <= 1'b1;
                    end else if (w_next) begin
                        r_op <= iOP;
                    end else if (w_dig_acc) begin
                        r_b <= shift_digit(r_b, iDIGIT);
                    end
                end
                S_SEND: begin
                    // Operands frozen while the set is offered.
                end
                S_DONE: begin
                    if (w_next) begin
                        // Chaining: the previous A is kept as the new left operand.
                        r_op <= iOP;
                        r_b  <= '0;
                    end else if (w_dig_acc) begin
                        r_a <= {3'b000, iDIGIT};
                        r_b <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Entry FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------
    // Entry FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_clr) begin
            w_next_state = S_A;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_next) begin
                        w_next_state = S_B;
                    end
                end
                S_B: begin
                    if (w_exec && !w_div0) begin
                        w_next_state = S_SEND;
                    end
                end
                S_SEND: begin
                    if (iREADY) begin
                        w_next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_next) begin
                        w_next_state = S_B;
                    end else if (w_dig_acc) begin
                        w_next_state = S_A;
                    end
                end
                default: begin
                    w_next_state = S_A;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Entry FSM: outputs (decoded from state so reset drops oVALID at once)
    // ---------------------------------------------------------------
    always_comb begin
        oVALID = 1'b0;
        oSEL_B = 1'b0;
        case (r_state)
            S_B:     oSEL_B = 1'b1;
            S_SEND:  oVALID = 1'b1;
            default: begin
            end
        endcase
    end

    assign oA     = r_a;
    assign oB     = r_b;
    assign oOP    = r_op;
    assign oERR   = r_err;
    assign oSTATE = r_state;

endmodule
